// File: rtl/sar_adc_ctrl_if.sv
// Conversion handshake and analog-side signals of the SAR controller.
// The master modport is the controller; the slave modport is whatever sits
// on the other side: the analog macro and the requester.
interface sar_adc_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             cmp_in;
  logic             sample_o;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    input  start,
    input  cmp_in,
    output sample_o,
    output dac_code,
    output busy,
    output done,
    output result
  );

  modport slave (
    output start,
    output cmp_in,
    input  sample_o,
    input  dac_code,
    input  busy,
    input  done,
    input  result
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller.
// Drives the R-2R DAC trial code and the track/hold switch, and reads back the
// asynchronous comparator through a 2-flop synchronizer. It runs one
// MSB-first binary search per accepted start and presents the result with a
// one-cycle done strobe. Every output comes straight from a flop.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  sar_adc_ctrl_if.master   bus
);

  localparam int MAX_CNT = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    SETTLE,
    DECIDE,
    DONE
  } state_e;

  state_e           state_q;
  logic             cmpMeta_q;
  logic             cmpSync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] bitIdx_q;
  logic             sample_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] dacCode_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] bitMask_d;
  logic [WIDTH-1:0] decided_d;

  // Bring the raw comparator into the clock domain; only cmpSync_q is used downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmpMeta_q <= 1'b0;
      cmpSync_q <= 1'b0;
    end else begin
      cmpMeta_q <= bus.cmp_in;
      cmpSync_q <= cmpMeta_q;
    end
  end

  // Trial code with the bit under test resolved by the synchronized comparator
  always_comb begin
    bitMask_d = '0;
    decided_d = '0;
    bitMask_d = WIDTH'(1) << bitIdx_q;
    decided_d = cmpSync_q ? dacCode_q : (dacCode_q & ~bitMask_d);
  end

  // Conversion sequencer: sample, then settle/decide once per bit, MSB first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitIdx_q  <= '0;
      sample_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dacCode_q <= '0;
      result_q  <= '0;
    end else if (!ena) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitIdx_q  <= '0;
      sample_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dacCode_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          sample_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          if (bus.start) begin
            state_q   <= SAMPLE;
            sample_q  <= 1'b1;
            busy_q    <= 1'b1;
            dacCode_q <= '0;
            cnt_q     <= CNT_W'(SAMPLE_CYCLES - 1);
          end
        end
        SAMPLE: begin
          if (cnt_q == '0) begin
            state_q   <= SETTLE;
            sample_q  <= 1'b0;
            dacCode_q <= MSB_CODE;
            bitIdx_q  <= IDX_W'(WIDTH - 1);
            cnt_q     <= CNT_W'(SETTLE_CYCLES - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= DECIDE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DECIDE: begin
          if (bitIdx_q == '0) begin
            state_q   <= DONE;
            dacCode_q <= decided_d;
            result_q  <= decided_d;
            done_q    <= 1'b1;
          end else begin
            state_q   <= SETTLE;
            dacCode_q <= decided_d | (bitMask_d >> 1);
            bitIdx_q  <= bitIdx_q - 1'b1;
            cnt_q     <= CNT_W'(SETTLE_CYCLES - 1);
          end
        end
        DONE: begin
          state_q   <= IDLE;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          dacCode_q <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.sample_o = sample_q;
  assign bus.dac_code = dacCode_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Testbench for sar_adc_ctrl with default parameters.
// An ideal comparator closes the loop around the DAC code. Expected results
// and done edges are queued when a start is accepted, and a negedge monitor
// pops the queue and compares them whenever done is seen.
module tb_sar_adc_ctrl;

  localparam int WIDTH   = 8;
  localparam int N_EDGES = 36;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               doneEdge;
  } exp_t;

  logic clk;
  logic rst_n;
  logic ena;
  logic [WIDTH-1:0] vIn;
  int   edgeCnt;
  int   testsRun;
  int   testsFailed;
  bit   prevDone;
  exp_t sbQ[$];
  logic [WIDTH-1:0] trials [6];

  sar_adc_ctrl_if #(.WIDTH(WIDTH)) busIf ();

  sar_adc_ctrl #(
    .WIDTH(WIDTH),
    .SAMPLE_CYCLES(4),
    .SETTLE_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .bus(busIf.master)
  );

  // Ideal comparator: high when the analog input is at or above the DAC voltage
  assign busIf.cmp_in = (vIn >= busIf.dac_code);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so the expected done times can be stated in edges
  initial edgeCnt = 0;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Raise start, note the accepting edge and queue the expected result
  task automatic applyStimulus(input logic [WIDTH-1:0] v, output int accept);
    @(negedge clk);
    vIn = v;
    busIf.start = 1'b1;
    @(posedge clk);
    #1;
    accept = edgeCnt;
    sbQ.push_back('{res: v, doneEdge: accept + N_EDGES});
    @(negedge clk);
    busIf.start = 1'b0;
  endtask

  // Wait for done, with a cycle budget so a stuck design still ends the run
  task automatic waitDone(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busIf.done) return;
    end
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL done_timeout: got no done, expected done within %0d cycles", budget);
  endtask

  // Scoreboard monitor: every done must match the head of the queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (prevDone) checkOutput("done_width", 32'(busIf.done), 32'd0);
      if (busIf.done) begin
        if (sbQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_done: got done with result %0h, expected none", busIf.result);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("result", 32'(busIf.result), 32'(e.res));
          checkOutput("done_edge", 32'(edgeCnt), 32'(e.doneEdge));
        end
      end
      prevDone = busIf.done;
    end else begin
      prevDone = 1'b0;
    end
  end

  initial begin
    int a;
    trials = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4};
    testsRun    = 0;
    testsFailed = 0;
    prevDone    = 1'b0;
    rst_n       = 1'b0;
    ena         = 1'b1;
    vIn         = '0;
    busIf.start = 1'b0;

    // Reset state
    #3;
    checkOutput("rst_sample", 32'(busIf.sample_o), 32'd0);
    checkOutput("rst_dac", 32'(busIf.dac_code), 32'd0);
    checkOutput("rst_busy", 32'(busIf.busy), 32'd0);
    checkOutput("rst_done", 32'(busIf.done), 32'd0);
    checkOutput("rst_result", 32'(busIf.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // V=0xA5 with per-cycle checks of sample_o, busy and the trial codes
    applyStimulus(8'hA5, a);
    for (int r = 0; r <= 37; r++) begin
      if (r > 0) @(negedge clk);
      checkOutput($sformatf("sample_r%0d", r), 32'(busIf.sample_o), (r < 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("busy_r%0d", r), 32'(busIf.busy), (r <= 36) ? 32'd1 : 32'd0);
      for (int k = 0; k < 6; k++)
        if (r == 5 + 4 * k) checkOutput($sformatf("trial%0d", k), 32'(busIf.dac_code), 32'(trials[k]));
    end
    checkOutput("idle_dac", 32'(busIf.dac_code), 32'd0);

    // Boundary codes
    applyStimulus(8'h00, a);
    waitDone(60);
    applyStimulus(8'hFF, a);
    waitDone(60);
    applyStimulus(8'h80, a);
    waitDone(60);

    // start pulsed mid-conversion is ignored
    applyStimulus(8'h3C, a);
    repeat (9) @(negedge clk);
    busIf.start = 1'b1;
    @(negedge clk);
    busIf.start = 1'b0;
    checkOutput("busy_ignore", 32'(busIf.busy), 32'd1);
    waitDone(60);
    repeat (45) @(negedge clk);

    // Abort via ena at edge 20; result must keep 0x3C and no done appears
    applyStimulus(8'h5A, a);
    repeat (19) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busIf.busy), 32'd0);
    checkOutput("abort_sample", 32'(busIf.sample_o), 32'd0);
    checkOutput("abort_dac", 32'(busIf.dac_code), 32'd0);
    checkOutput("abort_done", 32'(busIf.done), 32'd0);
    checkOutput("abort_result", 32'(busIf.result), 32'h3C);
    void'(sbQ.pop_back());
    repeat (45) @(negedge clk);
    ena = 1'b1;
    applyStimulus(8'h5A, a);
    waitDone(60);

    // start held high: conversions every 38 edges, input changed after each done
    @(negedge clk);
    vIn = 8'h37;
    busIf.start = 1'b1;
    @(posedge clk);
    #1;
    a = edgeCnt;
    sbQ.push_back('{res: 8'h37, doneEdge: a + N_EDGES});
    sbQ.push_back('{res: 8'hC8, doneEdge: a + N_EDGES + 38});
    sbQ.push_back('{res: 8'h01, doneEdge: a + N_EDGES + 76});
    waitDone(60);
    vIn = 8'hC8;
    waitDone(60);
    vIn = 8'h01;
    waitDone(60);
    busIf.start = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-SETTLE clears everything without a clock edge
    applyStimulus(8'h99, a);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_sample", 32'(busIf.sample_o), 32'd0);
    checkOutput("arst_dac", 32'(busIf.dac_code), 32'd0);
    checkOutput("arst_busy", 32'(busIf.busy), 32'd0);
    checkOutput("arst_done", 32'(busIf.done), 32'd0);
    checkOutput("arst_result", 32'(busIf.result), 32'd0);
    sbQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_busy", 32'(busIf.busy), 32'd0);
    applyStimulus(8'h42, a);
    waitDone(60);
    repeat (3) @(negedge clk);

    checkOutput("queue_empty", 32'(sbQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Digital successive-approximation controller that sits directly upstream of the analog macro in the tile.
- Drives the analog macro's R-2R DAC code and sample switch through the dedicated outputs.
- Receives the analog comparator decision back through a dedicated input.
- Runs one binary-search conversion per start request and presents the WIDTH-bit result with a one-cycle done strobe.
- In the top-level wrapper: dac_code drives uo_out, cmp_in comes from ui_in[0], start comes from ui_in[1], and result is exposed on uio_out.

Parameters:
WIDTH, 8, conversion resolution in bits (legal 2..8).
SAMPLE_CYCLES, 4, clock periods sample_o is held high (legal >=1).
SETTLE_CYCLES, 3, periods waited per bit before deciding. Must be >=3 to cover DAC settling plus the 2-flop comparator synchronizer.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  tile enable; low aborts and holds block idle
start  input  1  conversion request, level-sampled in IDLE
cmp_in  input  1  raw async comparator output; 1 = analog input >= DAC voltage
sample_o  output  1  track/hold switch control, high = tracking
dac_code  output  WIDTH  trial code to DAC
busy  output  1  high from start acceptance until the done cycle inclusive
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  last completed conversion, held until next done

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; sample_o=0, dac_code=0, busy=0, done=0, result=0.
  - Both synchronizer flops cleared.
  - Counters and bit index cleared.
- cmp_in passes through a 2-flop synchronizer (cmp_s). Only cmp_s is used.
- All outputs are registered.
- State machine: IDLE, SAMPLE, SETTLE, DECIDE, DONE.
  - IDLE:
    - sample_o=0, busy=0.
    - On a clock edge with start=1 and ena=1: go to SAMPLE, sample_o<=1, busy<=1, dac_code<=0, cnt<=SAMPLE_CYCLES-1.
  - SAMPLE:
    - cnt decrements each cycle.
    - At cnt==0: sample_o<=0, dac_code<=1<<(WIDTH-1), bit_idx<=WIDTH-1, cnt<=SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE:
    - cnt decrements each cycle.
    - At cnt==0: go to DECIDE.
  - DECIDE (exactly one cycle):
    - If cmp_s=0, clear dac_code[bit_idx]; if cmp_s=1, keep it.
    - If bit_idx==0: go to DONE.
    - Otherwise: set dac_code[bit_idx-1], bit_idx decrements, cnt<=SETTLE_CYCLES-1, go to SETTLE.
    - The bit clear and the next-bit set land on the same edge.
  - DONE (one cycle):
    - done=1, busy=1.
    - result takes the final dac_code.
    - Next edge: go to IDLE with done=0, busy=0, dac_code<=0.
- Latency:
  - DONE is entered on edge N = SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1), counted after the edge that accepted start.
  - Defaults give N=36. done is high for the period after edge N.
- Back-to-back: start held high re-triggers on the edge that leaves DONE→IDLE+1, i.e. the first IDLE cycle. Minimum spacing between conversions is N+2 edges.
- start while busy is ignored; no queuing.
- ena=0 in any state:
  - Next edge forces IDLE with sample_o=0, dac_code=0, busy=0, done=0.
  - result is unchanged.
  - No done is produced for the aborted conversion.
- An asynchronous reset mid-conversion clears everything, including result.
- Arithmetic is bitwise only; no overflow is possible. A final code of all-ones is legal.

Test Plan:
- Reset values: assert rst_n low mid-SETTLE -> all outputs 0 immediately, without waiting for a clock edge. After release, block is in IDLE.
- Ideal comparator model, cmp_in = (V >= dac_code), V=0xA5, defaults:
  - done pulses exactly 36 edges after start acceptance, for one cycle.
  - result=0xA5.
  - dac_code trial sequence starts 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4.
- Boundary codes: V=0x00 -> result=0x00. V=0xFF -> result=0xFF. V=0x80 -> result=0x80.
- sample_o timing: high for exactly 4 cycles starting the cycle after start acceptance. Low for the rest of the conversion.
- Abort: drop ena at edge 20 of a V=0x5A conversion -> IDLE next edge, no done, result keeps its previous value. Re-enable plus start -> fresh conversion gives 0x5A.
- Protocol:
  - start pulsed during busy -> ignored.
  - start held high continuously -> conversions repeat with done pulses 38 edges apart, each result correct.
